uart_tx_arbiter: RTL

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte sources. It accepts one byte per grant and drives the transmitter's `enable`/`i_data` inputs. It holds `i_data` stable for the whole frame, because the transmitter has no data latch of its own. It sits between the on-chip requesters (command responder, debug logger, status reporter) and the `UART` instance's Tx port.

---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter sharing one UART transmitter among NUM_REQ
//            byte sources. One byte is captured per grant. The captured byte
//            is held on uart_data for the whole frame, because the
//            transmitter has no data latch of its own.
// Ports    : clk, reset_n           - clock, asynchronous active-low reset
//            req[NUM_REQ]           - level requests, held until ack
//            req_data               - packed request bytes, byte i at
//                                     [i*DATA_WIDTH +: DATA_WIDTH]
//            req_lock[NUM_REQ]      - burst-hold hint (lock build only)
//            ack[NUM_REQ]           - one-cycle capture pulse
//            done[NUM_REQ]          - one-cycle frame-complete pulse
//            gnt_id                 - current / last granted requester
//            active                 - high from capture until done
//            uart_enable, uart_data - to UART enable / i_data
//            uart_busy              - from UART o_busy
// Options  : UART_TX_ARB_LOCK_EN - when defined, a grant captured with its
//            req_lock bit high gives that requester priority at the next
//            arbitration, provided its req is still high.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            done,
    output logic [ID_WIDTH-1:0]           gnt_id,
    output logic                          active,
    output logic                          uart_enable,
    output logic [DATA_WIDTH-1:0]         uart_data,
    input  logic                          uart_busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    // Previous winner starts at the top index so requester 0 wins first.
    localparam logic [ID_WIDTH-1:0] c_LAST_INIT = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  c_ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_nxt_state;
    logic [ID_WIDTH-1:0]   r_last;
    logic [ID_WIDTH-1:0]   w_nxt_last;
    logic [ID_WIDTH-1:0]   r_gnt_id;
    logic [ID_WIDTH-1:0]   w_nxt_gnt_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_nxt_data;
    logic [NUM_REQ-1:0]    r_ack;
    logic [NUM_REQ-1:0]    w_nxt_ack;
    logic [NUM_REQ-1:0]    r_done;
    logic [NUM_REQ-1:0]    w_nxt_done;
    logic                  r_active;
    logic                  w_nxt_active;
    logic                  r_enable;
    logic                  w_nxt_enable;

    logic [ID_WIDTH-1:0]   w_rr_id;
    logic [ID_WIDTH-1:0]   w_winner;
    logic [DATA_WIDTH-1:0] w_req_bytes [NUM_REQ];

    // Unpack the flat request bus into one byte per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first set req bit from r_last+1 upward, wrapping.
    always_comb begin
        logic w_found;
        int   w_idx;
        w_found = 1'b0;
        w_rr_id = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = int'(r_last) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_found && req[ID_WIDTH'(w_idx)]) begin
                w_found = 1'b1;
                w_rr_id = ID_WIDTH'(w_idx);
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    logic r_lock;
    logic w_nxt_lock;

    // A locked requester keeps the transmitter only while it still requests;
    // otherwise rotation resumes from r_last, which equals r_gnt_id here.
    assign w_winner = (r_lock && req[r_gnt_id]) ? r_gnt_id : w_rr_id;
`else
    logic w_unused_lock;

    assign w_unused_lock = ^req_lock;
    assign w_winner      = w_rr_id;
`endif

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_last   = r_last;
        w_nxt_gnt_id = r_gnt_id;
        w_nxt_data   = r_data;
        w_nxt_ack    = '0;
        w_nxt_done   = '0;
        w_nxt_active = r_active;
        w_nxt_enable = r_enable;
`ifdef UART_TX_ARB_LOCK_EN
        w_nxt_lock   = r_lock;
`endif
        case (r_state)
            ST_IDLE: begin
                if ((|req) && !uart_busy) begin
                    w_nxt_state  = ST_LAUNCH;
                    w_nxt_data   = w_req_bytes[w_winner];
                    w_nxt_gnt_id = w_winner;
                    w_nxt_last   = w_winner;
                    w_nxt_ack    = c_ONE_HOT0 << w_winner;
                    w_nxt_active = 1'b1;
                    w_nxt_enable = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
                    w_nxt_lock   = req_lock[w_winner];
`endif
                end
            end
            ST_LAUNCH: begin
                // The transmitter starts on its own baud tick, so this wait
                // has no bound; busy high means the byte is being sent.
                if (uart_busy) begin
                    w_nxt_enable = 1'b0;
                    w_nxt_state  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_busy) begin
                    w_nxt_done   = c_ONE_HOT0 << r_gnt_id;
                    w_nxt_active = 1'b0;
                    w_nxt_state  = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_last   <= c_LAST_INIT;
            r_gnt_id <= '0;
            r_data   <= '0;
            r_ack    <= '0;
            r_done   <= '0;
            r_active <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_last   <= w_nxt_last;
            r_gnt_id <= w_nxt_gnt_id;
            r_data   <= w_nxt_data;
            r_ack    <= w_nxt_ack;
            r_done   <= w_nxt_done;
            r_active <= w_nxt_active;
            r_enable <= w_nxt_enable;
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lock <= 1'b0;
        end else begin
            r_lock <= w_nxt_lock;
        end
    end
`endif

    assign ack         = r_ack;
    assign done        = r_done;
    assign gnt_id      = r_gnt_id;
    assign active      = r_active;
    assign uart_enable = r_enable;
    assign uart_data   = r_data;

endmodule
`default_nettype wire
